// File: rtl/ema_filter_mc.sv
// ---------------------------------------------------------------------------
// ema_filter_mc
// Multi-channel, time-interleaved exponential moving average filter for the
// AGC level-detection path: y[c] += alpha * (x - y[c]), where
// alpha = coef / 2^CWIDTH. An attack coefficient is used when the sample is
// above the channel state, and a decay coefficient otherwise.
//
// Pipeline (edges counted from the accept edge E0):
//   E0: capture y (with forwarding), diff = x_ext - y, coefficient select
//   E1: exact product diff * coef
//   E2: rounded update, y_new = sat(y + upd)
//   E3: state write-back, registered outputs (out_valid pulses here)
// A sample of the same channel may be accepted at E3 at the earliest. Its
// state read is then forwarded from the value being written at that edge.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is combinational on in_ch
//   in_ch, in_data        channel index and signed sample
//   coef_attack/decay     unsigned coefficients (quasi-static)
//   clr                   synchronous clear of all states and in-flight data
//   out_valid, out_ch     single-cycle result strobe and its channel
//   out_data              rounded, saturated result (DWIDTH)
//   out_state             full-precision updated state (SW)
// ---------------------------------------------------------------------------
module ema_filter_mc #(
    parameter  int NCH    = 4,
    parameter  int DWIDTH = 27,
    parameter  int CWIDTH = 18,
    parameter  int FRAC   = 14,
    localparam int SW     = DWIDTH + FRAC,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHW-1:0]           in_ch,
    input  logic signed [DWIDTH-1:0] in_data,
    input  logic [CWIDTH-1:0]        coef_attack,
    input  logic [CWIDTH-1:0]        coef_decay,
    input  logic                     clr,
    output logic                     out_valid,
    output logic [CHW-1:0]           out_ch,
    output logic signed [DWIDTH-1:0] out_data,
    output logic signed [SW-1:0]     out_state
);

    // Product width holds the exact signed (SW+1) x (CWIDTH+1) product.
    localparam int PW = SW + CWIDTH + 2;
    // Width of the scaled update and of y + upd (no overflow possible).
    localparam int UW = PW - CWIDTH;
    // Width used while rounding the state down to the output precision.
    localparam int OW = SW + 1;

    localparam logic signed [PW-1:0] P_HALF =
        {{(PW-CWIDTH){1'b0}}, 1'b1, {(CWIDTH-1){1'b0}}};
    localparam logic signed [OW-1:0] F_HALF =
        {{(OW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [UW-1:0] SW_MAX =
        {{(UW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [UW-1:0] SW_MIN =
        {{(UW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    localparam logic signed [OW-1:0] DW_MAX =
        {{(OW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [OW-1:0] DW_MIN =
        {{(OW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    // Clamp a wide signed value into the SW-bit state range.
    function automatic logic signed [SW-1:0] sat_sw(input logic signed [UW-1:0] v);
        logic signed [SW-1:0] r;
        if (v > SW_MAX) begin
            r = SW_MAX[SW-1:0];
        end else if (v < SW_MIN) begin
            r = SW_MIN[SW-1:0];
        end else begin
            r = v[SW-1:0];
        end
        return r;
    endfunction

    // Clamp the rounded state into the DWIDTH-bit output range.
    function automatic logic signed [DWIDTH-1:0] sat_dw(input logic signed [OW-1:0] v);
        logic signed [DWIDTH-1:0] r;
        if (v > DW_MAX) begin
            r = DW_MAX[DWIDTH-1:0];
        end else if (v < DW_MIN) begin
            r = DW_MIN[DWIDTH-1:0];
        end else begin
            r = v[DWIDTH-1:0];
        end
        return r;
    endfunction

    logic signed [SW-1:0]     state_r [NCH];

    logic                     v1_r;
    logic [CHW-1:0]           ch1_r;
    logic signed [SW-1:0]     y1_r;
    logic signed [SW:0]       diff1_r;
    logic [CWIDTH-1:0]        coef1_r;

    logic                     v2_r;
    logic [CHW-1:0]           ch2_r;
    logic signed [SW-1:0]     y2_r;
    logic signed [PW-1:0]     prod2_r;

    logic                     v3_r;
    logic [CHW-1:0]           ch3_r;
    logic signed [SW-1:0]     y_new3_r;

    logic                     hazard_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic signed [SW-1:0]     x_ext_s;
    logic signed [SW-1:0]     y_rd_s;
    logic signed [SW-1:0]     y_fwd_s;
    logic signed [SW:0]       diff_s;
    logic [CWIDTH-1:0]        coef_s;
    logic signed [PW-1:0]     diff_ext_s;
    logic signed [PW-1:0]     coef_ext_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [UW-1:0]     upd_s;
    logic signed [UW-1:0]     y2_ext_s;
    logic signed [UW-1:0]     sum_s;
    logic signed [SW-1:0]     y_new_s;
    logic signed [OW-1:0]     out_pre_s;
    logic signed [DWIDTH-1:0] out_data_s;
    logic                     ch_ok_s;

    // Only S1 and S2 can hold stale state; S3 is covered by forwarding.
    assign hazard_s   = in_valid & ((v1_r & (ch1_r == in_ch)) | (v2_r & (ch2_r == in_ch)));
    assign in_ready_s = rst_n & ~hazard_s & ~clr;
    assign in_ready   = in_ready_s;
    assign accept_s   = in_valid & in_ready_s;

    assign x_ext_s = {in_data, {FRAC{1'b0}}};

    // Channel state read mux; out-of-range channels read as zero.
    always_comb begin
        y_rd_s = '0;
        for (int i = 0; i < NCH; i++) begin
            y_rd_s = (in_ch == CHW'(i)) ? state_r[i] : y_rd_s;
        end
    end

    assign y_fwd_s = (v3_r && (ch3_r == in_ch)) ? y_new3_r : y_rd_s;
    assign diff_s  = $signed({x_ext_s[SW-1], x_ext_s}) - $signed({y_fwd_s[SW-1], y_fwd_s});
    assign coef_s  = (x_ext_s > y_fwd_s) ? coef_attack : coef_decay;

    // Coefficient is unsigned, so it enters the signed multiply zero-extended.
    assign diff_ext_s = {{(PW-SW-1){diff1_r[SW]}}, diff1_r};
    assign coef_ext_s = {{(PW-CWIDTH){1'b0}}, coef1_r};
    assign prod_s     = diff_ext_s * coef_ext_s;

    // Round half up, then drop the coefficient fraction bits.
    assign upd_s    = UW'((prod2_r + P_HALF) >>> CWIDTH);
    assign y2_ext_s = {{(UW-SW){y2_r[SW-1]}}, y2_r};
    assign sum_s    = y2_ext_s + upd_s;
    assign y_new_s  = sat_sw(sum_s);

    assign out_pre_s  = OW'(($signed({y_new3_r[SW-1], y_new3_r}) + F_HALF) >>> FRAC);
    assign out_data_s = sat_dw(out_pre_s);

    // Non-power-of-two channel counts let in_ch address a channel that does
    // not exist; such samples flow through but produce nothing.
    if (NCH == (1 << CHW)) begin : g_ch_full
        assign ch_ok_s = 1'b1;
    end else begin : g_ch_part
        assign ch_ok_s = (ch3_r < CHW'(NCH));
    end

    // Pipeline registers S1..S3; clr drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            ch1_r    <= '0;
            y1_r     <= '0;
            diff1_r  <= '0;
            coef1_r  <= '0;
            v2_r     <= 1'b0;
            ch2_r    <= '0;
            y2_r     <= '0;
            prod2_r  <= '0;
            v3_r     <= 1'b0;
            ch3_r    <= '0;
            y_new3_r <= '0;
        end else if (clr) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                ch1_r   <= in_ch;
                y1_r    <= y_fwd_s;
                diff1_r <= diff_s;
                coef1_r <= coef_s;
            end
            v2_r     <= v1_r;
            ch2_r    <= ch1_r;
            y2_r     <= y1_r;
            prod2_r  <= prod_s;
            v3_r     <= v2_r;
            ch3_r    <= ch2_r;
            y_new3_r <= y_new_s;
        end
    end

    // Per-channel state write-back; clr takes priority over a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (v3_r && (ch3_r == CHW'(i))) begin
                    state_r[i] <= y_new3_r;
                end
            end
        end
    end

    // Registered result outputs; data holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_state <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3_r & ch_ok_s;
            if (v3_r && ch_ok_s) begin
                out_ch    <= ch3_r;
                out_data  <= out_data_s;
                out_state <= y_new3_r;
            end
        end
    end

endmodule
